// File: rtl/muldiv_sched.sv
// rtl/muldiv_sched.sv - EXE-stage multiply/divide sequencer with HI/LO commit
module muldiv_sched #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_valid,
  input  logic [3:0]  exe_op,
  input  logic        exe_wr,
  input  logic        flush,
  input  logic [31:0] op_b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  input  logic [63:0] mul_prod,
  input  logic        div_done,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic        mul_start,
  output logic        div_start,
  output logic        div_abort,
  output logic        op_signed,
  output logic        stall,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_MUL_WAIT, S_DIV_WAIT, S_DONE} state_t;

  localparam int CW = ($clog2(MUL_LAT) > 3) ? $clog2(MUL_LAT) : 3;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MSUB  = 4'd7;
  localparam logic [3:0] OP_MSUBU = 4'd8;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        is_mul, is_div, go;
  logic [63:0] acc_base, mul_wdata;

  assign is_mul = (exe_op == OP_MULT) || (exe_op == OP_MULTU) ||
                  (exe_op == OP_MADD) || (exe_op == OP_MADDU) ||
                  (exe_op == OP_MSUB) || (exe_op == OP_MSUBU);
  assign is_div = (exe_op == OP_DIV) || (exe_op == OP_DIVU);
  assign go     = exe_valid & (is_mul | is_div) & ~flush;

  assign op_signed = (exe_op == OP_MULT) || (exe_op == OP_DIV) ||
                     (exe_op == OP_MADD) || (exe_op == OP_MSUB);

  // Accumulate uses HI/LO as seen in the completion cycle; EXE is stalled so exe_op is stable.
  assign acc_base = {hi_in, lo_in};
  always_comb begin
    mul_wdata = mul_prod;
    if ((exe_op == OP_MADD) || (exe_op == OP_MADDU)) begin
      mul_wdata = acc_base + mul_prod;
    end else if ((exe_op == OP_MSUB) || (exe_op == OP_MSUBU)) begin
      mul_wdata = acc_base - mul_prod;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_start = 1'b0;
    div_start = 1'b0;
    div_abort = 1'b0;
    stall     = 1'b0;
    hilo_we   = 1'b0;
    hi_wdata  = mul_wdata[63:32];
    lo_wdata  = mul_wdata[31:0];
    busy      = (state_q == S_MUL_WAIT) || (state_q == S_DIV_WAIT);

    case (state_q)
      S_IDLE: begin
        if (go && is_mul) begin
          mul_start = 1'b1;
          stall     = 1'b1;
          cnt_d     = CNT_INIT;
          state_d   = S_MUL_WAIT;
        end else if (go && is_div) begin
          // Divide by zero retires without touching HI/LO or the divider.
          if (op_b != 32'd0) begin
            div_start = 1'b1;
            stall     = 1'b1;
            state_d   = S_DIV_WAIT;
          end else begin
            state_d   = S_DONE;
          end
        end
      end
      S_MUL_WAIT: begin
        if (cnt_q != '0) begin
          stall = 1'b1;
          cnt_d = cnt_q - CW'(1);
        end else begin
          hilo_we = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DIV_WAIT: begin
        if (div_done) begin
          hilo_we  = 1'b1;
          hi_wdata = div_r;
          lo_wdata = div_q;
          state_d  = S_DONE;
        end else begin
          stall = 1'b1;
        end
      end
      S_DONE: begin
        if (exe_wr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      mul_start = 1'b0;
      div_start = 1'b0;
      stall     = 1'b0;
      hilo_we   = 1'b0;
      busy      = 1'b0;
      div_abort = (state_q == S_DIV_WAIT);
    end

    // Outputs drop as soon as reset asserts, without waiting for a clock.
    if (!resetn) begin
      mul_start = 1'b0;
      div_start = 1'b0;
      div_abort = 1'b0;
      stall     = 1'b0;
      hilo_we   = 1'b0;
      busy      = 1'b0;
    end
  end

endmodule

// File: tb/tb_muldiv_sched.sv
// tb/tb_muldiv_sched.sv - scoreboard bench for muldiv_sched
module tb_muldiv_sched;
  localparam int MUL_LAT = 2;
  localparam int K_MUL = 0;
  localparam int K_DIV = 1;
  localparam int K_WE  = 2;
  localparam int K_ABT = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        exe_valid = 1'b0;
  logic [3:0]  exe_op = 4'd0;
  logic        exe_wr = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] hi_in = 32'd0;
  logic [31:0] lo_in = 32'd0;
  logic [63:0] mul_prod = 64'd0;
  logic        div_done = 1'b0;
  logic [31:0] div_q = 32'd0;
  logic [31:0] div_r = 32'd0;
  logic        mul_start, div_start, div_abort, op_signed, stall, hilo_we, busy;
  logic [31:0] hi_wdata, lo_wdata;

  muldiv_sched #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .exe_op(exe_op),
    .exe_wr(exe_wr), .flush(flush), .op_b(op_b), .hi_in(hi_in), .lo_in(lo_in),
    .mul_prod(mul_prod), .div_done(div_done), .div_q(div_q), .div_r(div_r),
    .mul_start(mul_start), .div_start(div_start), .div_abort(div_abort),
    .op_signed(op_signed), .stall(stall), .hilo_we(hilo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] hi, input logic [31:0] lo);
    ev_t e;
    e.kind = kind; e.cyc = c; e.hi = hi; e.lo = lo;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input logic [31:0] hi, input logic [31:0] lo);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, nothing expected", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || (kind == K_WE && (e.hi !== hi || e.lo !== lo))) begin
        n_fail++;
        $display("FAIL event: got kind %0d cyc %0d hi %h lo %h, expected kind %0d cyc %0d hi %h lo %h",
                 kind, cyc, hi, lo, e.kind, e.cyc, e.hi, e.lo);
      end
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (mul_start) pop_cmp(K_MUL, 32'd0, 32'd0);
      if (div_start) pop_cmp(K_DIV, 32'd0, 32'd0);
      if (hilo_we)   pop_cmp(K_WE, hi_wdata, lo_wdata);
      if (div_abort) pop_cmp(K_ABT, 32'd0, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exe_valid = 1'b0; exe_op = 4'd0; exe_wr = 1'b0; flush = 1'b0; div_done = 1'b0;
  endtask

  task automatic do_mul(input logic [3:0] op, input logic [31:0] hin, input logic [31:0] lin,
                        input logic [63:0] prod, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic esigned, input int hold);
    int t;
    exe_valid = 1'b1; exe_op = op; hi_in = hin; lo_in = lin; mul_prod = prod;
    exe_wr = 1'b0; flush = 1'b0;
    t = cyc;
    push(K_MUL, t, 32'd0, 32'd0);
    push(K_WE, t + MUL_LAT, ehi, elo);
    #2;
    check("mul_issue_stall", stall, 1);
    check("mul_op_signed", op_signed, esigned);
    for (int i = 1; i < MUL_LAT; i++) begin
      tick(); #2;
      check("mul_wait_stall", stall, 1);
      check("mul_wait_busy", busy, 1);
    end
    tick(); #2;
    check("mul_complete_stall", stall, 0);
    for (int i = 0; i < hold; i++) begin
      tick(); #2;
      check("done_hold_stall", stall, 0);
      check("done_hold_busy", busy, 0);
    end
    tick();
    exe_wr = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic do_div(input logic [3:0] op, input logic [31:0] b, input logic [31:0] q,
                        input logic [31:0] r, input int lat, input logic esigned);
    int t;
    int nst;
    exe_valid = 1'b1; exe_op = op; op_b = b; div_q = q; div_r = r; exe_wr = 1'b0;
    t = cyc;
    nst = 0;
    push(K_DIV, t, 32'd0, 32'd0);
    push(K_WE, t + lat, r, q);
    #2;
    check("div_op_signed", op_signed, esigned);
    if (stall) nst++;
    for (int i = 1; i < lat; i++) begin
      tick(); #2;
      if (stall) nst++;
    end
    tick();
    div_done = 1'b1;
    #2;
    check("div_done_stall", stall, 0);
    check("div_stall_cycles", nst, lat);
    tick();
    div_done = 1'b0;
    exe_wr = 1'b1;
    tick();
    clear_inputs();
  endtask

  initial begin
    exe_valid = 1'b1; exe_op = 4'd1;
    #3;
    check("reset_mul_start", mul_start, 0);
    check("reset_stall", stall, 0);
    check("reset_busy", busy, 0);
    check("reset_hilo_we", hilo_we, 0);
    check("reset_div_start", div_start, 0);
    check("reset_div_abort", div_abort, 0);
    check("reset_op_signed", op_signed, 1);
    clear_inputs();
    tick(); tick();
    resetn = 1'b1;
    tick();

    do_mul(4'd1, 32'd0, 32'd0, 64'hFFFF_FFFF_FFFF_FFF1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 0);
    do_mul(4'd6, 32'd0, 32'hFFFF_FFFF, 64'd1, 32'd1, 32'd0, 1'b0, 0);
    do_mul(4'd7, 32'd0, 32'd0, 64'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    do_mul(4'd8, 32'd0, 32'd10, 64'd3, 32'd0, 32'd7, 1'b0, 0);

    do_div(4'd3, 32'd7, 32'd3, 32'd1, 33, 1'b1);
    do_div(4'd4, 32'd100, 32'd14, 32'd2, 5, 1'b0);

    // divide by zero: no start, no stall, no write
    exe_valid = 1'b1; exe_op = 4'd4; op_b = 32'd0;
    #2;
    check("div0_stall", stall, 0);
    check("div0_start", div_start, 0);
    tick();
    exe_wr = 1'b1;
    #2;
    check("div0_done_busy", busy, 0);
    tick();
    clear_inputs();

    // completed MULT held in EXE for 4 cycles, then back-to-back MULTU
    do_mul(4'd1, 32'd0, 32'd0, 64'h0000_0001_0000_0002, 32'd1, 32'd2, 1'b1, 4);
    do_mul(4'd2, 32'd0, 32'd0, 64'h0000_0002_0000_0003, 32'd2, 32'd3, 1'b0, 0);

    // flush while in DIV_WAIT
    exe_valid = 1'b1; exe_op = 4'd3; op_b = 32'd7;
    push(K_DIV, cyc, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b1; exe_valid = 1'b0;
    push(K_ABT, cyc, 32'd0, 32'd0);
    #2;
    check("flush_div_stall", stall, 0);
    check("flush_div_busy", busy, 0);
    tick();
    flush = 1'b0;
    #2;
    check("after_flush_busy", busy, 0);
    check("after_flush_abort", div_abort, 0);
    tick();

    // flush coincident with div_done
    exe_valid = 1'b1; exe_op = 4'd3; op_b = 32'd7;
    push(K_DIV, cyc, 32'd0, 32'd0);
    tick(); tick();
    div_done = 1'b1; flush = 1'b1; exe_valid = 1'b0;
    push(K_ABT, cyc, 32'd0, 32'd0);
    #2;
    check("flush_divdone_we", hilo_we, 0);
    tick();
    clear_inputs();

    // flush coincident with multiply completion
    exe_valid = 1'b1; exe_op = 4'd1; mul_prod = 64'd5;
    push(K_MUL, cyc, 32'd0, 32'd0);
    tick(); tick();
    flush = 1'b1; exe_valid = 1'b0;
    #2;
    check("flush_mul_we", hilo_we, 0);
    tick();
    clear_inputs();
    #2;
    check("flush_mul_busy", busy, 0);
    tick();

    // async reset mid MUL_WAIT
    exe_valid = 1'b1; exe_op = 4'd1;
    push(K_MUL, cyc, 32'd0, 32'd0);
    tick(); #2;
    check("pre_reset_busy", busy, 1);
    #1;
    resetn = 1'b0; clear_inputs();
    #1;
    check("async_reset_stall", stall, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_we", hilo_we, 0);
    tick(); tick();
    resetn = 1'b1;
    #2;
    check("post_reset_busy", busy, 0);
    tick();
    do_mul(4'd5, 32'd1, 32'd1, 64'h0000_0001_FFFF_FFFF, 32'd3, 32'd0, 1'b1, 0);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
